// File: rtl/nv_io_axil_regfile_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the NV IO register file.
// Field names follow the AXI signal names so an instance named S_AXI reads as S_AXI.AWADDR etc.
interface nv_io_axil_regfile_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/nv_io_axil_regfile.sv
// AXI4-Lite register file of the NV IO controller: four RW words to the IO core,
// synchronised io_in status and a write-1-to-clear rising-edge latch with interrupt.
module nv_io_axil_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int N_IN               = 16,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  nv_io_axil_regfile_if.slave           S_AXI,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
  input  logic [N_IN-1:0]               io_in,
  output logic                          edge_irq_o
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  typedef logic [IW-1:0] idx_t;
  localparam idx_t IDX_STATUS = idx_t'(4);
  localparam idx_t IDX_EDGE   = idx_t'(5);

  typedef enum logic {W_IDLE, W_RESP} wState_e;
  typedef enum logic {R_IDLE, R_DATA} rState_e;

  wState_e           wState_q;
  rState_e           rState_q;
  logic [DW-1:0]     regs_q [4];
  logic              awReady_q, wReady_q, bValid_q, arReady_q, rValid_q;
  logic [1:0]        bResp_q, rResp_q;
  logic [DW-1:0]     rData_q;
  logic              awHeld_q, wHeld_q;
  idx_t              awIdx_q;
  logic [DW-1:0]     wData_q;
  logic [DW/8-1:0]   wStrb_q;
  logic [N_IN-1:0]   sync_q [SYNC_STAGES];
  logic [N_IN-1:0]   statusPrev_q;
  logic [DW-1:0]     edge_q, edge_d;

  logic              awTake, wTake, awHave, wHave, doWrite;
  idx_t              wrIdx, rdIdx;
  logic [DW-1:0]     wrData, byteMask, edgeClr, statusExt, riseExt, rdMux;
  logic [DW/8-1:0]   wrStrb;
  logic              rdErr;
  logic              unusedBits;

  // AW and W may land in different cycles; each is parked until its partner arrives.
  always_comb begin
    awTake   = S_AXI.AWVALID && awReady_q;
    wTake    = S_AXI.WVALID && wReady_q;
    awHave   = awHeld_q || awTake;
    wHave    = wHeld_q || wTake;
    doWrite  = (wState_q == W_IDLE) && awHave && wHave;
    wrIdx    = awTake ? S_AXI.AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awIdx_q;
    wrData   = wTake ? S_AXI.WDATA : wData_q;
    wrStrb   = wTake ? S_AXI.WSTRB : wStrb_q;
    byteMask = '0;
    for (int k = 0; k < DW/8; k++) byteMask[8*k +: 8] = {8{wrStrb[k]}};
    edgeClr  = (doWrite && wrIdx == IDX_EDGE) ? (wrData & byteMask) : '0;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wState_q  <= W_IDLE;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
      bResp_q   <= 2'b00;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awIdx_q   <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      case (wState_q)
        W_IDLE: begin
          if (doWrite) begin
            if (wrIdx < idx_t'(4))
              regs_q[wrIdx[1:0]] <= (regs_q[wrIdx[1:0]] & ~byteMask) | (wrData & byteMask);
            bResp_q   <= (wrIdx > IDX_EDGE) ? 2'b10 : 2'b00;
            bValid_q  <= 1'b1;
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            wState_q  <= W_RESP;
          end else begin
            if (awTake) awIdx_q <= S_AXI.AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            if (wTake) begin
              wData_q <= S_AXI.WDATA;
              wStrb_q <= S_AXI.WSTRB;
            end
            awHeld_q  <= awHave;
            wHeld_q   <= wHave;
            awReady_q <= !awHave;
            wReady_q  <= !wHave;
          end
        end
        W_RESP: begin
          if (S_AXI.BREADY) begin
            bValid_q  <= 1'b0;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b1;
            wState_q  <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Edge latch looks one stage past the synchroniser; a same-cycle rise beats the clear.
  always_comb begin
    statusExt = '0;
    statusExt[N_IN-1:0] = sync_q[SYNC_STAGES-1];
    riseExt = '0;
    riseExt[N_IN-1:0] = sync_q[SYNC_STAGES-1] & ~statusPrev_q;
    edge_d = (edge_q & ~edgeClr) | riseExt;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      statusPrev_q <= '0;
      edge_q       <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      statusPrev_q <= sync_q[SYNC_STAGES-1];
      edge_q       <= edge_d;
    end
  end

  always_comb begin
    rdIdx = S_AXI.ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    rdMux = '0;
    rdErr = 1'b0;
    case (rdIdx)
      idx_t'(0):  rdMux = regs_q[0];
      idx_t'(1):  rdMux = regs_q[1];
      idx_t'(2):  rdMux = regs_q[2];
      idx_t'(3):  rdMux = regs_q[3];
      IDX_STATUS: rdMux = statusExt;
      IDX_EDGE:   rdMux = edge_q;
      default:    rdErr = 1'b1;
    endcase
  end

  // One read outstanding; data is captured from pre-write state when AR and a write share an edge.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rState_q  <= R_IDLE;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= 2'b00;
    end else begin
      case (rState_q)
        R_IDLE: begin
          if (arReady_q && S_AXI.ARVALID) begin
            rData_q   <= rdMux;
            rResp_q   <= rdErr ? 2'b10 : 2'b00;
            rValid_q  <= 1'b1;
            arReady_q <= 1'b0;
            rState_q  <= R_DATA;
          end else begin
            arReady_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI.RREADY) begin
            rValid_q  <= 1'b0;
            arReady_q <= 1'b1;
            rState_q  <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign S_AXI.AWREADY = awReady_q;
  assign S_AXI.WREADY  = wReady_q;
  assign S_AXI.BVALID  = bValid_q;
  assign S_AXI.BRESP   = bResp_q;
  assign S_AXI.ARREADY = arReady_q;
  assign S_AXI.RVALID  = rValid_q;
  assign S_AXI.RDATA   = rData_q;
  assign S_AXI.RRESP   = rResp_q;
  assign reg0_o        = regs_q[0];
  assign reg1_o        = regs_q[1];
  assign reg2_o        = regs_q[2];
  assign reg3_o        = regs_q[3];
  assign edge_irq_o    = |edge_q;
  assign unusedBits    = ^{S_AXI.AWPROT, S_AXI.ARPROT, S_AXI.AWADDR[1:0], S_AXI.ARADDR[1:0]};
endmodule
